// File: rtl/cpu_pkg.sv
// Shared state encoding, op-code constants and op-class helpers for the
// multi-cycle RV32I sequencer.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [OP_W-1:0] OP_LB    = 6'd19;
  localparam logic [OP_W-1:0] OP_LH    = 6'd20;
  localparam logic [OP_W-1:0] OP_LW    = 6'd21;
  localparam logic [OP_W-1:0] OP_LBU   = 6'd22;
  localparam logic [OP_W-1:0] OP_LHU   = 6'd23;
  localparam logic [OP_W-1:0] OP_SB    = 6'd24;
  localparam logic [OP_W-1:0] OP_SH    = 6'd25;
  localparam logic [OP_W-1:0] OP_SW    = 6'd26;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd27;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd28;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd29;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd30;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd31;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd32;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd33;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd34;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd35;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd36;

  function automatic logic is_load(input logic [OP_W-1:0] op_v);
    return (op_v >= OP_LB) && (op_v <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op_v);
    return (op_v >= OP_SB) && (op_v <= OP_SW);
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op_v);
    return (op_v >= OP_BEQ) && (op_v <= OP_BGEU);
  endfunction

  function automatic logic is_jump(input logic [OP_W-1:0] op_v);
    return (op_v == OP_JAL) || (op_v == OP_JALR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by instruction fetch and data access; flags the
// cycle in which one more unacknowledged request cycle hits the limit.
module mem_wait_timer
  import cpu_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_c
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds completed waits, so the current cycle is wait number count_q+1
  assign at_limit_c = (count_q == WAIT_W'(LIMIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the RV32I core: owns the PC, fetches and latches
// instructions, sequences DECODE/EXEC/MEM/WB. Build option: ILLEGAL_TRAP_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic [XLEN-1:0]      imem_rdata,
  input  logic                 imem_ack,
  output logic [XLEN-1:0]      instr_q,
  input  logic [OP_W-1:0]      op,
  input  logic                 dec_we,
  input  logic                 take_branch,
  input  logic [XLEN-1:0]      pc_target,
  output logic                 dmem_req,
  output logic                 dmem_wr,
  input  logic                 dmem_ack,
  output logic                 rf_we,
  output logic [XLEN-1:0]      pc,
  output logic                 bus_err,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret
);

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        instr_d;
  logic                   imem_req_q, imem_req_d;
  logic                   dmem_req_q, dmem_req_d;
  logic                   dmem_wr_q, dmem_wr_d;
  logic                   rf_we_q, rf_we_d;
  logic                   bus_err_q, bus_err_d;
  logic                   trap_q, trap_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  logic                   tmr_clr;
  logic                   tmr_inc;
  logic                   tmr_at_limit;
  logic                   is_mem;
  logic                   redirect;
  logic                   unused_tgt_lsb;

  assign is_mem   = is_load(op) || is_store(op);
  assign redirect = is_jump(op) || (is_branch(op) && take_branch);

  // Targets are word aligned; the low bits of pc_target are discarded.
  assign unused_tgt_lsb = ^pc_target[1:0];

`ifdef ILLEGAL_TRAP_EN
  logic illegal;
  assign illegal = (op == '0) && !dec_we;
`endif

  mem_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (tmr_clr),
    .inc_i      (tmr_inc),
    .at_limit_c (tmr_at_limit)
  );

  // Next-state and next-output logic; every output register is loaded here.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    dmem_wr_d  = 1'b0;
    rf_we_d    = 1'b0;
    bus_err_d  = 1'b0;
    trap_d     = 1'b0;
    instret_d  = instret_q;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (!imem_req_q) begin
          imem_req_d = 1'b1;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end else if (tmr_at_limit) begin
          bus_err_d = 1'b1;
          tmr_clr   = 1'b1;
        end else begin
          imem_req_d = 1'b1;
          tmr_inc    = 1'b1;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (illegal) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
        end
`endif
      end

      ST_EXEC: begin
        if (is_mem) begin
          state_d    = ST_MEM;
          dmem_req_d = 1'b1;
          dmem_wr_d  = is_store(op);
          tmr_clr    = 1'b1;
        end else begin
          state_d = ST_WB;
          rf_we_d = dec_we;
        end
      end

      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_WB;
          rf_we_d = dec_we;
        end else if (tmr_at_limit) begin
          // Abort: refetch the same PC, nothing retires.
          bus_err_d  = 1'b1;
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
          tmr_clr    = 1'b1;
        end else begin
          dmem_req_d = 1'b1;
          dmem_wr_d  = dmem_wr_q;
          tmr_inc    = 1'b1;
        end
      end

      ST_WB: begin
        pc_d       = redirect ? {pc_target[XLEN-1:2], 2'b00} : pc_q + XLEN'(4);
        instret_d  = instret_q + INSTRET_W'(1);
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
        tmr_clr    = 1'b1;
      end

      ST_TRAP: begin
        pc_d       = TRAP_VEC;
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
        tmr_clr    = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_wr_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      trap_q     <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_wr_q  <= dmem_wr_d;
      rf_we_q    <= rf_we_d;
      bus_err_q  <= bus_err_d;
      trap_q     <= trap_d;
      instret_q  <= instret_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_wr   = dmem_wr_q;
  assign rf_we     = rf_we_q;
  assign pc        = pc_q;
  assign bus_err   = bus_err_q;
  assign trap      = trap_q;
  assign instret   = instret_q;

endmodule
